// File: rtl/draw_player_pkg.sv
// Purpose: shared VGA constants/types and draw_player local types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    typedef logic [11:0] pos_t;

    // Colour key used by sprite ROMs to mark see-through pixels.
    localparam logic [11:0] TRANSPARENT_RGB = 12'h0_f_0;

endpackage

package draw_player_pkg;

    import vga_pkg::*;

    typedef enum logic {
        ANIM_IDLE = 1'b0,
        ANIM_WALK = 1'b1
    } anim_state_t;

    // One registered copy of every timing/colour field of the stream.
    typedef struct packed {
        pos_t        vcount;
        logic        vsync;
        logic        vblnk;
        pos_t        hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_sig_t;

    localparam logic [11:0] BBOX_RGB = 12'hf_0_0;

    function automatic pos_t clamp_pos(input pos_t p, input pos_t lim);
        return (p > lim) ? lim : p;
    endfunction

endpackage

// File: rtl/draw_player_if.sv
// Purpose: VGA pixel stream bundle (counters, syncs, blanks, colour).
// Latency: n/a (wiring only).
// Backpressure: none; the stream advances every pixel clock.
// Modports: master drives the stream, slave consumes it.
interface vga_if;
    import vga_pkg::*;

    pos_t        vcount;
    logic        vsync;
    logic        vblnk;
    pos_t        hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_player_anim_fsm.sv
// Purpose: walk-animation sequencer, stepped once per video frame.
// Latency: frame index updates on the clock after frame_tick.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), frame_tick (one pulse per frame),
//        moved (position changed at this tick), frame (sprite frame index).
module player_anim_fsm
    import draw_player_pkg::*;
#(
    parameter int NFRAMES  = 4,
    parameter int ANIM_DIV = 8,
    parameter int FW       = $clog2(NFRAMES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic          moved,
    output logic [FW-1:0] frame
);

    localparam int CW = $clog2(ANIM_DIV + 1);

    anim_state_t   state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [CW-1:0] anim_q,  anim_d;
    logic [CW-1:0] still_q, still_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ANIM_IDLE;
            frame_q <= '0;
            anim_q  <= '0;
            still_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            anim_q  <= anim_d;
            still_q <= still_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        anim_d  = anim_q;
        still_d = still_q;
        if (frame_tick) begin
            case (state_q)
                ANIM_IDLE: begin
                    frame_d = '0;
                    anim_d  = '0;
                    still_d = '0;
                    if (moved) state_d = ANIM_WALK;
                end
                ANIM_WALK: begin
                    still_d = moved ? '0 : still_q + CW'(1);
                    if (!moved && still_q == CW'(ANIM_DIV - 1)) begin
                        // ANIM_DIV static frames in a row: back to idle pose.
                        state_d = ANIM_IDLE;
                        frame_d = '0;
                        anim_d  = '0;
                        still_d = '0;
                    end else if (anim_q == CW'(ANIM_DIV - 1)) begin
                        anim_d  = '0;
                        // Frame 0 is the idle pose, so the walk cycle skips it.
                        frame_d = (frame_q == FW'(NFRAMES - 1)) ? FW'(1) : frame_q + FW'(1);
                    end else begin
                        anim_d  = anim_q + CW'(1);
                    end
                end
                default: state_d = ANIM_IDLE;
            endcase
        end
    end

    always_comb begin
        frame = (state_q == ANIM_IDLE) ? '0 : frame_q;
    end

endmodule

// File: rtl/draw_player.sv
// Purpose: overlays an animated WIDTH x HEIGHT player sprite on a VGA stream.
// Latency: exactly 2 clk on every vga_out field; rom_addr is 1 clk after vga_in.
// Backpressure: none; one pixel per clk in and out.
// Ports: clk, rst (sync, active-high), vga_in (background), vga_out (overlaid),
//        xpos/ypos (sprite top-left request), rom_addr/rom_pixel (sprite ROM).
// Option: define DRAW_PLAYER_BBOX_EN to paint a 1-pixel red border on the sprite box.
module draw_player
    import vga_pkg::*;
    import draw_player_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          HEIGHT      = 48,
    parameter int          NFRAMES     = 4,
    parameter int          ANIM_DIV    = 8,
    parameter logic [11:0] TRANSPARENT = TRANSPARENT_RGB,
    parameter int          ADDR_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_if.slave                  vga_in,
    vga_if.master                 vga_out,
    input  pos_t                  xpos,
    input  pos_t                  ypos,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [11:0]           rom_pixel
);

    localparam int   FW    = $clog2(NFRAMES);
    localparam int   AW    = ADDR_WIDTH;
    localparam pos_t X_MAX = pos_t'(HOR_PIXELS - WIDTH);
    localparam pos_t Y_MAX = pos_t'(VER_PIXELS - HEIGHT);

    // ---------------- position latch (once per frame) ----------------
    logic          vblnk_prev;
    logic          frame_tick;
    pos_t          x_q, y_q, x_new, y_new;
    logic          moved;
    logic [FW-1:0] frame;

    assign frame_tick = vga_in.vblnk & ~vblnk_prev;
    assign x_new      = clamp_pos(xpos, X_MAX);
    assign y_new      = clamp_pos(ypos, Y_MAX);
    assign moved      = (x_new != x_q) || (y_new != y_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            vblnk_prev <= vga_in.vblnk;
            if (frame_tick) begin
                x_q <= x_new;
                y_q <= y_new;
            end
        end
    end

    player_anim_fsm #(
        .NFRAMES  (NFRAMES),
        .ANIM_DIV (ANIM_DIV),
        .FW       (FW)
    ) u_anim (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .moved      (moved),
        .frame      (frame)
    );

    // ---------------- stage 1: box test and ROM address ----------------
    // Box ends are computed one bit wider so the compare can never wrap.
    logic [12:0]   x_end, y_end;
    logic          in_box;
    logic [AW-1:0] addr_next;
    vga_sig_t      s1;
    logic          in_box_d;

    assign x_end  = {1'b0, x_q} + 13'(WIDTH - 1);
    assign y_end  = {1'b0, y_q} + 13'(HEIGHT - 1);
    assign in_box = (vga_in.hcount >= x_q) && ({1'b0, vga_in.hcount} <= x_end) &&
                    (vga_in.vcount >= y_q) && ({1'b0, vga_in.vcount} <= y_end);
    assign addr_next = AW'(frame) * AW'(WIDTH * HEIGHT)
                     + AW'(vga_in.vcount - y_q) * AW'(WIDTH)
                     + AW'(vga_in.hcount - x_q);

`ifdef DRAW_PLAYER_BBOX_EN
    logic border, border_d;
    assign border = in_box &&
                    ((vga_in.hcount == x_q) || (vga_in.hcount == x_end[11:0]) ||
                     (vga_in.vcount == y_q) || (vga_in.vcount == y_end[11:0]));

    always_ff @(posedge clk) begin
        if (rst) border_d <= 1'b0;
        else     border_d <= border;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            in_box_d <= 1'b0;
            rom_addr <= '0;
        end else begin
            s1       <= '{vcount: vga_in.vcount, vsync: vga_in.vsync, vblnk: vga_in.vblnk,
                          hcount: vga_in.hcount, hsync: vga_in.hsync, hblnk: vga_in.hblnk,
                          rgb: vga_in.rgb};
            in_box_d <= in_box;
            if (in_box) rom_addr <= addr_next;
        end
    end

    // ---------------- stage 2: colour select ----------------
    logic [11:0] pix;

    always_comb begin
        pix = s1.rgb;
        if (in_box_d && !s1.hblnk && !s1.vblnk) begin
`ifdef DRAW_PLAYER_BBOX_EN
            if (border_d)                       pix = BBOX_RGB;
            else if (rom_pixel != TRANSPARENT)  pix = rom_pixel;
`else
            if (rom_pixel != TRANSPARENT)       pix = rom_pixel;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.vcount <= '0;
            vga_out.vsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.vcount <= s1.vcount;
            vga_out.vsync  <= s1.vsync;
            vga_out.vblnk  <= s1.vblnk;
            vga_out.hcount <= s1.hcount;
            vga_out.hsync  <= s1.hsync;
            vga_out.hblnk  <= s1.hblnk;
            vga_out.rgb    <= pix;
        end
    end

endmodule

// File: tb/tb_draw_player.sv
// Purpose: randomized scoreboard bench for draw_player against a frame-level model.
// Latency: expects every output field 2 clk after the matching input pixel.
// Backpressure: n/a.
module tb_draw_player;
    import vga_pkg::*;

    localparam int W  = 32;
    localparam int H  = 48;
    localparam int NF = 4;
    localparam int AD = 8;
    localparam int XM = HOR_PIXELS - W;
    localparam int YM = VER_PIXELS - H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    pos_t        xpos = '0, ypos = '0;
    logic [12:0] rom_addr;
    logic [11:0] rom_pixel;
    int          cyc = 0;
    int          checks = 0, failures = 0;

    vga_if vin ();
    vga_if vout ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sprite ROM contents: every 7th word is the transparent key.
    function automatic logic [11:0] rom_fn(input int a);
        logic [11:0] v;
        if (a % 7 == 3) return 12'h0f0;
        v = 12'((a * 37 + 5) ^ (a >> 3));
        if (v == 12'h0f0) v = 12'h0f1;
        return v;
    endfunction

    assign rom_pixel = rom_fn(int'(rom_addr));

    draw_player #(
        .WIDTH(W), .HEIGHT(H), .NFRAMES(NF), .ANIM_DIV(AD),
        .TRANSPARENT(12'h0f0), .ADDR_WIDTH(13)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vga_in    (vin),
        .vga_out   (vout),
        .xpos      (xpos),
        .ypos      (ypos),
        .rom_addr  (rom_addr),
        .rom_pixel (rom_pixel)
    );

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic [27:0] tim;
    } exp_t;
    exp_t q[$];

    // Reference model state: latched position and walk-animation bookkeeping.
    int   mx, my, mframe, walking, still, steps;
    logic mprev;

    task automatic model_reset();
        mx = 0; my = 0; mframe = 0; walking = 0; still = 0; steps = 0; mprev = 1'b0;
    endtask

    task automatic model_new_frame(input int rx, input int ry);
        int nx, ny;
        bit mv;
        nx = (rx > XM) ? XM : rx;
        ny = (ry > YM) ? YM : ry;
        mv = (nx != mx) || (ny != my);
        if (!walking) begin
            mframe = 0;
            if (mv) begin walking = 1; still = 0; steps = 0; end
        end else begin
            still = mv ? 0 : still + 1;
            if (still == AD) begin
                walking = 0; mframe = 0;
            end else begin
                steps++;
                if (steps % AD == 0) mframe = (mframe == NF - 1) ? 1 : mframe + 1;
            end
        end
        mx = nx; my = ny;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Drive one input pixel; push its expected output unless in reset.
    task automatic drive(input int h, input int v);
        exp_t e;
        logic hb, vb, hs, vs;
        logic [11:0] bg, rp;
        bit inb;
        int a;
        hb = (h >= 800); vb = (v >= 600);
        hs = (h >= 840 && h < 968); vs = (v >= 601 && v < 605);
        bg = 12'($urandom);
        vin.hcount = 12'(h); vin.vcount = 12'(v);
        vin.hblnk = hb; vin.vblnk = vb; vin.hsync = hs; vin.vsync = vs; vin.rgb = bg;
        if (!rst) begin
            inb = (h >= mx) && (h <= mx + W - 1) && (v >= my) && (v <= my + H - 1);
            e.rgb = bg;
            if (inb && !hb && !vb) begin
                a = (mframe * W * H + (v - my) * W + (h - mx)) % 8192;
                rp = rom_fn(a);
                if (rp != 12'h0f0) e.rgb = rp;
`ifdef DRAW_PLAYER_BBOX_EN
                if (h == mx || h == mx + W - 1 || v == my || v == my + H - 1) e.rgb = 12'hf00;
`endif
            end
            e.tim = {12'(h), 12'(v), hs, vs, hb, vb};
            e.due = cyc + 2;
            q.push_back(e);
            if (vb && !mprev) model_new_frame(int'(xpos), int'(ypos));
            mprev = vb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 1000), $urandom_range(0, 620));
            chk("reset_rgb", {20'd0, vout.rgb}, 32'd0);
            chk("reset_timing", {4'd0, vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                                 vout.hblnk, vout.vblnk}, 32'd0);
            chk("reset_rom_addr", {19'd0, rom_addr}, 32'd0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    // One abbreviated frame: lines around the current sprite, then a vblank edge.
    task automatic run_frame(input int nx, input int ny, input int midx);
        int vl[6];
        int base;
        xpos = 12'(nx); ypos = 12'(ny);
        vl[0] = my - 1; vl[1] = my; vl[2] = my + int'($urandom_range(0, H - 1));
        vl[3] = my + H - 1; vl[4] = my + H; vl[5] = int'($urandom_range(0, 599));
        for (int l = 0; l < 6; l++) begin
            if (vl[l] < 0) vl[l] = 0;
            if (vl[l] > 599) vl[l] = 599;
            if (l == 3 && midx >= 0) xpos = 12'(midx);
            for (int h = 0; h < 4; h++) drive(h, vl[l]);
            base = (mx >= 3) ? mx - 3 : 0;
            for (int h = base; h <= mx + W + 2; h++) drive(h, vl[l]);
            base = int'($urandom_range(0, 1040));
            for (int h = base; h < base + 8; h++) drive(h, vl[l]);
        end
        for (int v = 600; v < 603; v++) drive($urandom_range(0, 1050), v);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].due < cyc) begin
            failures++;
            $display("FAIL missed_output: actual=none expected_due=%0d", q[0].due);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rgb", {20'd0, vout.rgb}, {20'd0, e.rgb});
            chk("timing", {4'd0, vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                           vout.hblnk, vout.vblnk}, {4'd0, e.tim});
        end
    end

    initial begin
        model_reset();
        vin.hcount = '0; vin.vcount = '0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
        vin.hsync = 1'b0; vin.vsync = 1'b0; vin.rgb = '0;
        #1;
        do_reset(3);
        // Latch (100,50), then draw there while latching 300 mid-frame.
        run_frame(100, 50, -1);
        run_frame(100, 50, 300);
        run_frame(300, 50, -1);
        // Clamp to the bottom-right corner.
        run_frame(790, 590, -1);
        run_frame(790, 590, -1);
        run_frame(4095, 4095, -1);
        // Move every frame long enough to wrap the walk cycle.
        for (int f = 0; f < 30; f++) run_frame((f % 2) ? 200 : 210, 100, -1);
        // Stand still until the idle pose returns.
        for (int f = 0; f < 10; f++) run_frame(210, 100, -1);
        // Reset mid-line, then recover.
        for (int h = 0; h < 10; h++) drive(300 + h, 120);
        do_reset(2);
        for (int f = 0; f < 15; f++)
            run_frame($urandom_range(0, 4095), $urandom_range(0, 700),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 900)) : -1);
        repeat (3) @(posedge clk);
        #1;
        chk("drain", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
